io_mode_exerciser: RTL and testbench
====================================

# io_mode_exerciser

Parametrised successor to the team's plain 8-bit I/O pass-through user module. It keeps the same 8-in/8-out user-module pin frame, but dedicates two pins to clock and reset and registers every output. It adds four run-time modes: pass, delay-line, hold and accumulate. It sits directly behind the user-module pin frame and serves bring-up of the scan chain and I/O path: latency, data integrity and clocking can each be checked from the pins alone.

## Interface
- DATA_W, 4: data nibble width; fixed by pin budget (DATA_W + 4 ≤ 8); io_out carries 2×DATA_W bits.
- DEPTH, 4: delay-line depth in cycles; legal 1..16.
- io_in[0]  input  1  clock; all state updates on rising edge.
- io_in[1]  input  1  reset; synchronous, active-high; priority over all other inputs.
- io_in[3:2]  input  2  mode: 00 PASS, 01 DELAY, 10 HOLD, 11 ACCUM.
- io_in[7:4]  input  DATA_W  data d.
- io_out[7:0]  output  8  registered result; no combinational path from io_in.

## Operation
- State:
  - out_q[7:0], drives io_out.
  - d_q[3:0], previous-cycle d.
  - dl[0..DEPTH-1], each DATA_W wide, delay line.
  - acc[7:0], accumulator.
- Reset edge (io_in[1]=1):
  - out_q, d_q, every dl entry and acc are cleared to 0.
  - Mode and data are ignored.
- Every non-reset edge, regardless of mode:
  - d_q <= d.
  - dl[0] <= d; dl[i] <= dl[i-1].
  - The tap is dl[DEPTH-1] as it was before this edge, i.e. d sampled DEPTH edges earlier.
- Mode is sampled at the same edge as d; there is no mode-change pipeline and no settling cycle.
- PASS (00): out_q <= {d_q, d}.
  - Upper nibble: previous d. Lower nibble: current d.
- DELAY (01): out_q <= {d ^ tap, tap}.
  - Upper nibble is a mismatch vector against the delayed copy.
- HOLD (10): out_q unchanged; acc unchanged; delay line and d_q keep shifting.
- ACCUM (11): acc <= acc + zero_ext(d), modulo 256; out_q <= same new value.
  - d=0 freezes the count.
- acc changes only in ACCUM mode or on reset. Leaving ACCUM and returning resumes from the retained value.
- Wrap-around: 8-bit unsigned, no saturation, no carry flag (e.g. 0xFE + 0x3 = 0x01).
- Simultaneous reset and any mode: reset wins; io_out = 0x00 after that edge.

## Timing
- Latency from io_in change to io_out:
  - PASS lower nibble: 1 edge.
  - PASS upper nibble: 2 edges.
  - DELAY lower nibble: DEPTH+1 edges from d capture to visibility.
  - ACCUM: 1 edge.
- After reset, the first DEPTH non-reset edges in DELAY output tap=0, so the upper nibble equals d.
- Reset mid-operation, in any mode and at any cycle: all state is 0 on the following edge; no partial flush.
- Outputs change only on rising clock edges; io_out is stable for the full cycle.

## Test plan
- Reset: hold io_in[1]=1 for 2 edges with mode=11, d=0xF -> io_out=0x00 after the first reset edge and stays 0x00; acc=0.
- PASS: after reset, mode=00, apply d=0x3 then 0xA on successive edges -> io_out=0x03, then 0x3A.
- DELAY, DEPTH=4: mode=01, apply d=1,2,3,4,5,6 on edges 1..6.
  - Edges 1..4 -> io_out=0x10, 0x20, 0x30, 0x40.
  - Edge 5 -> 0x41 (5^1, tap 1).
  - Edge 6 -> 0x42.
- HOLD: from io_out=0x3A, mode=10, toggle d for 5 edges -> io_out stays 0x3A; then switch to PASS -> io_out reflects the current d and d_q immediately.
- ACCUM wrap: reset, mode=11, d=0xF for 17 edges -> io_out reads 0xFF at edge 17; one more edge with d=0x3 -> 0x02.
- ACCUM retention plus mid-run reset:
  - Accumulate to 0x20, HOLD 3 edges, return to ACCUM with d=1 -> 0x21.
  - Assert reset during ACCUM -> 0x00 on that edge, and accumulation restarts from 0 on release.

Source files
------------

// File: rtl/io_mode_exerciser.sv
// io_mode_exerciser: 8-in/8-out pin-frame exerciser with a registered output.
// io_in[0] is the clock, io_in[1] is a synchronous reset and io_in[3:2] selects the mode.
// The modes are pass, delay-line, hold and accumulate.
// io_in[4 +: DATA_W] carries the data nibble d.
module io_mode_exerciser #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_DELAY = 2'b01,
    MODE_HOLD  = 2'b10,
    MODE_ACCUM = 2'b11
  } mode_e;

  logic              clk;
  logic              rst;
  mode_e             mode;
  logic [DATA_W-1:0] d;

  assign clk  = io_in[0];
  assign rst  = io_in[1];
  assign mode = mode_e'(io_in[3:2]);
  assign d    = io_in[4 +: DATA_W];

  logic [7:0]        out_q;
  logic [7:0]        acc;
  logic [DATA_W-1:0] d_q;
  logic [DATA_W-1:0] dl [DEPTH];
  logic [DATA_W-1:0] tap;

  logic [7:0]        out_next;
  logic [7:0]        acc_next;

  // The tap is the oldest delay-line entry, i.e. d sampled DEPTH edges ago.
  assign tap    = dl[DEPTH-1];
  assign io_out = out_q;

  // Mode decode: next output and accumulator values; hold keeps both.
  always_comb begin
    out_next = out_q;
    acc_next = acc;
    unique case (mode)
      MODE_PASS:  out_next = 8'({d_q, d});
      MODE_DELAY: out_next = 8'({d ^ tap, tap});
      MODE_HOLD:  ;
      MODE_ACCUM: begin
        acc_next = acc + 8'(d);
        out_next = acc_next;
      end
      default:    ;
    endcase
  end

  // State register. Reset clears everything. Otherwise d_q and the delay line shift in every mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      acc   <= '0;
      d_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dl[i] <= '0;
      end
    end else begin
      out_q <= out_next;
      acc   <= acc_next;
      d_q   <= d;
      dl[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        dl[i] <= dl[i-1];
      end
    end
  end

endmodule

// File: tb/tb_io_mode_exerciser.sv
// Directed plus random bench for io_mode_exerciser.
// Every vector pushes the model's expected io_out into a scoreboard queue. The bench pops it and compares after the edge.
module tb_io_mode_exerciser;

  localparam int unsigned DEPTH = 4;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] d    = 4'h0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {d, mode, rst, clk};

  io_mode_exerciser #(.DATA_W(4), .DEPTH(DEPTH)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Reference model state
  logic [7:0] m_out = 8'h00;
  logic [7:0] m_acc = 8'h00;
  logic [3:0] m_dq  = 4'h0;
  logic [3:0] m_dl [DEPTH];
  logic       have_prev = 1'b0;

  logic [7:0] expq [$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: io_out=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model one edge from the spec and push the expected output.
  task automatic model_edge(input logic r, input logic [1:0] m, input logic [3:0] dd);
    logic [3:0] t;
    if (r) begin
      m_out = 8'h00;
      m_acc = 8'h00;
      m_dq  = 4'h0;
      for (int i = 0; i < DEPTH; i++) m_dl[i] = 4'h0;
    end else begin
      t = m_dl[DEPTH-1];
      case (m)
        2'b00: m_out = {m_dq, dd};
        2'b01: m_out = {dd ^ t, t};
        2'b10: ;
        default: begin
          m_acc = m_acc + {4'h0, dd};
          m_out = m_acc;
        end
      endcase
      for (int i = DEPTH - 1; i > 0; i--) m_dl[i] = m_dl[i-1];
      m_dl[0] = dd;
      m_dq    = dd;
    end
    expq.push_back(m_out);
  endtask

  // Apply one vector and check the scoreboard entry after the edge.
  // If lit_en is set, also compare io_out against a hand-derived constant.
  task automatic step(input string tag, input logic r, input logic [1:0] m, input logic [3:0] dd,
                      input logic lit_en, input logic [7:0] lit);
    logic [7:0] prev;
    logic [7:0] exp;
    @(negedge clk);
    prev = io_out;
    rst  = r;
    mode = m;
    d    = dd;
    model_edge(r, m, dd);
    #1;
    if (have_prev) check({tag, "_stable"}, io_out, prev);
    @(posedge clk);
    #1;
    if (expq.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_sb: scoreboard empty, io_out=%h expected=entry", tag, io_out);
    end else begin
      exp = expq.pop_front();
      check(tag, io_out, exp);
    end
    if (lit_en) check({tag, "_lit"}, io_out, lit);
    have_prev = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_dl[i] = 4'h0;

    // Reset held two edges with mode=ACCUM, d=F
    step("rst0", 1'b1, 2'b11, 4'hF, 1'b1, 8'h00);
    step("rst1", 1'b1, 2'b11, 4'hF, 1'b1, 8'h00);

    // PASS
    step("pass0", 1'b0, 2'b00, 4'h3, 1'b1, 8'h03);
    step("pass1", 1'b0, 2'b00, 4'hA, 1'b1, 8'h3A);

    // HOLD while d toggles, then back to PASS
    step("hold0", 1'b0, 2'b10, 4'h5, 1'b1, 8'h3A);
    step("hold1", 1'b0, 2'b10, 4'hA, 1'b1, 8'h3A);
    step("hold2", 1'b0, 2'b10, 4'h5, 1'b1, 8'h3A);
    step("hold3", 1'b0, 2'b10, 4'hA, 1'b1, 8'h3A);
    step("hold4", 1'b0, 2'b10, 4'hC, 1'b1, 8'h3A);
    step("hold_pass", 1'b0, 2'b00, 4'h7, 1'b1, 8'hC7);

    // DELAY after reset; taps stay zero for DEPTH edges
    step("drst", 1'b1, 2'b01, 4'h9, 1'b1, 8'h00);
    step("dly1", 1'b0, 2'b01, 4'h1, 1'b1, 8'h10);
    step("dly2", 1'b0, 2'b01, 4'h2, 1'b1, 8'h20);
    step("dly3", 1'b0, 2'b01, 4'h3, 1'b1, 8'h30);
    step("dly4", 1'b0, 2'b01, 4'h4, 1'b1, 8'h40);
    step("dly5", 1'b0, 2'b01, 4'h5, 1'b1, 8'h41);
    step("dly6", 1'b0, 2'b01, 4'h6, 1'b1, 8'h42);

    // ACCUM wrap: 17 * 0xF = 0xFF, then +3 -> 0x02
    step("arst", 1'b1, 2'b11, 4'h0, 1'b1, 8'h00);
    for (int i = 1; i <= 16; i++) step("acc_f", 1'b0, 2'b11, 4'hF, 1'b0, 8'h00);
    step("acc17", 1'b0, 2'b11, 4'hF, 1'b1, 8'hFF);
    step("acc_wrap", 1'b0, 2'b11, 4'h3, 1'b1, 8'h02);

    // Retention across HOLD, then a mid-run reset
    step("rrst", 1'b1, 2'b00, 4'h0, 1'b1, 8'h00);
    step("racc1", 1'b0, 2'b11, 4'hF, 1'b1, 8'h0F);
    step("racc2", 1'b0, 2'b11, 4'hF, 1'b1, 8'h1E);
    step("racc3", 1'b0, 2'b11, 4'h2, 1'b1, 8'h20);
    step("rhold1", 1'b0, 2'b10, 4'h6, 1'b1, 8'h20);
    step("rhold2", 1'b0, 2'b10, 4'h9, 1'b1, 8'h20);
    step("rhold3", 1'b0, 2'b10, 4'hB, 1'b1, 8'h20);
    step("racc4", 1'b0, 2'b11, 4'h1, 1'b1, 8'h21);
    step("rmid", 1'b1, 2'b11, 4'h5, 1'b1, 8'h00);
    step("rrestart", 1'b0, 2'b11, 4'h4, 1'b1, 8'h04);
    step("rfreeze", 1'b0, 2'b11, 4'h0, 1'b1, 8'h04);
    step("rpass", 1'b0, 2'b00, 4'h8, 1'b1, 8'h08);

    // Random mix against the model, with occasional resets
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 1'b0, 8'h00);
    end

    if (expq.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL sb_drain: %0d entries left, expected 0", expq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
